// File: rtl/arm_fetch_pkg.sv
// Shared constants and types for the ARM fetch queue.
// Latency and backpressure: none; this package holds definitions only.
// Count width helper: sized so the counter can represent a completely full queue.
package arm_fetch_pkg;

  localparam int PC_STEP    = 4;
  localparam int R15_OFFSET = 8;
  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arm_fetch_fifo.sv
// Circular buffer with a registered head entry; flush empties it and zeroes both pointers.
// Latency: 1 cycle from push to rdata. Backpressure: full blocks push unless a pop occurs the same cycle.
// Empty: rdata keeps the last head value.
module arm_fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int              WIDTH   = 64,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             AW      = $clog2(DEPTH),
  localparam int             CW      = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && !flush && ((count_q < CW'(DEPTH)) || pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    rdata_d = rdata_q;
    if (flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else if (count_d != '0) begin
      // New head is the slot being written this edge only when the queue drains to it.
      if (push_ok && (rptr_d == wptr_q)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[rptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= RST_VAL;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;

endmodule

// File: rtl/arm_fetch_queue.sv
// ARM fetch stage: owns PCF and buffers {pc, instr} pairs for Decode.
// Latency: 1 cycle fetch-to-InstrD. Backpressure: StallD holds the head; the queue fills, then PCF holds.
// A Writeback redirect empties the queue.
module arm_fetch_queue
  import arm_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           FetchEn,
  output logic [XLEN-1:0]                PCF,
  input  logic [XLEN-1:0]                InstrF,
  input  logic                           StallD,
  output logic                           ValidD,
  output logic [XLEN-1:0]                InstrD,
  output logic [XLEN-1:0]                PCPlus8D,
  input  logic                           PCSrcW,
  input  logic [XLEN-1:0]                ResultW,
  output logic [count_width(DEPTH)-1:0]  Count
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam entry_t HEAD_RST = '{pc: RESET_PC, instr: '0};

  entry_t          wr_ent, rd_ent;
  logic            push, pop;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pop    = ValidD && !StallD && !PCSrcW;
    push   = FetchEn && !PCSrcW && ((Count < CW'(DEPTH)) || pop);
    wr_ent = '{pc: pc_q, instr: InstrF};
    pc_d   = pc_q;
    if (PCSrcW) begin
      // Branch targets are word aligned; low bits of ResultW are discarded.
      pc_d = ResultW & ~XLEN'(3);
    end else if (push) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  arm_fetch_fifo #(
    .WIDTH   ($bits(entry_t)),
    .DEPTH   (DEPTH),
    .RST_VAL (HEAD_RST)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (PCSrcW),
    .wdata (wr_ent),
    .rdata (rd_ent),
    .count (Count)
  );

  assign PCF      = pc_q;
  assign ValidD   = (Count != '0);
  assign InstrD   = rd_ent.instr;
  assign PCPlus8D = rd_ent.pc + XLEN'(R15_OFFSET);

endmodule

// File: tb/tb_arm_fetch_queue.sv
// Directed and random stimulus for arm_fetch_queue, checked against a queue-based model.
module tb_arm_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, FetchEn, StallD, PCSrcW, ValidD;
  logic [31:0] PCF, InstrF, InstrD, PCPlus8D, ResultW;
  logic [2:0]  Count;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'hE3A0_0001 ^ (a * 32'h9E37_79B1);
  endfunction

  assign InstrF = imem(PCF);

  arm_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .FetchEn(FetchEn), .PCF(PCF), .InstrF(InstrF),
    .StallD(StallD), .ValidD(ValidD), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .PCSrcW(PCSrcW), .ResultW(ResultW), .Count(Count)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_hpc, m_hinstr;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_hpc    = RESET_PC;
    m_hinstr = 32'h0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_pcf"},   PCF, m_pc);
    chk({ph, "_count"}, {29'b0, Count}, q.size());
    chk({ph, "_valid"}, {31'b0, ValidD}, (q.size() != 0) ? 32'd1 : 32'd0);
    chk({ph, "_instr"}, InstrD, m_hinstr);
    chk({ph, "_pc8"},   PCPlus8D, m_hpc + 32'd8);
  endtask

  task automatic step(input bit fen, input bit stall, input bit pcsrc, input logic [31:0] res);
    bit   pop, push;
    ent_t e;
    FetchEn = fen; StallD = stall; PCSrcW = pcsrc; ResultW = res;
    pop  = (q.size() != 0) && !stall && !pcsrc;
    push = fen && !pcsrc && ((q.size() < DEPTH) || pop);
    if (pcsrc) begin
      q.delete();
      m_pc = res & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = m_pc; e.instr = imem(m_pc);
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (q.size() != 0) begin
      m_hpc = q[0].pc; m_hinstr = q[0].instr;
    end
    @(posedge clk); #1;
    check_all("step");
  endtask

  initial begin
    reset = 1'b0; FetchEn = 1'b0; StallD = 1'b0; PCSrcW = 1'b0; ResultW = 32'h0;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_held");
    reset = 1'b1;

    // First fetch appears one cycle later; steady state holds one entry.
    step(1, 0, 0, 32'h0);
    chk("t1_instr", InstrD, 32'hE3A0_0001);
    chk("t1_pc8", PCPlus8D, 32'd8);
    chk("t1_pcf", PCF, 32'd4);
    repeat (3) step(1, 0, 0, 32'h0);
    chk("t1_count", {29'b0, Count}, 32'd1);

    // Stall fills the queue, PCF stops at 16, then drain in order.
    step(0, 0, 1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 32'h0);
      chk("t2_count", {29'b0, Count}, (i < 4) ? i + 1 : 4);
    end
    chk("t2_pcf", PCF, 32'd16);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", PCPlus8D, i * 4 + 8);
      step(0, 0, 0, 32'h0);
    end
    chk("t2_empty", {31'b0, ValidD}, 32'd0);

    // Full queue with concurrent push and pop.
    step(0, 0, 1, 32'h0);
    repeat (4) step(1, 1, 0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 32'h0);
      chk("t3_count", {29'b0, Count}, 32'd4);
      chk("t3_pcf", PCF, 32'd16 + 32'(i + 1) * 32'd4);
    end

    // Redirect with three entries queued; low target bits cleared.
    step(0, 0, 1, 32'h0);
    repeat (3) step(1, 1, 0, 32'h0);
    chk("t4_count3", {29'b0, Count}, 32'd3);
    step(1, 0, 1, 32'h0000_0103);
    chk("t4_count0", {29'b0, Count}, 32'd0);
    chk("t4_valid", {31'b0, ValidD}, 32'd0);
    chk("t4_pcf", PCF, 32'h0000_0100);
    step(1, 1, 0, 32'h0);
    chk("t4_instr", InstrD, imem(32'h0000_0100));
    chk("t4_pc8", PCPlus8D, 32'h0000_0108);

    // PC wrap at the top of the address space.
    step(0, 1, 1, 32'hFFFF_FFF8);
    chk("t5_pcf0", PCF, 32'hFFFF_FFF8);
    step(1, 1, 0, 32'h0);
    chk("t5_pcf1", PCF, 32'hFFFF_FFFC);
    step(1, 1, 0, 32'h0);
    chk("t5_pcf2", PCF, 32'h0000_0000);
    step(1, 1, 0, 32'h0);
    chk("t5_pcf3", PCF, 32'h0000_0004);
    chk("t5_pc8a", PCPlus8D, 32'h0000_0000);
    step(0, 0, 0, 32'h0);
    chk("t5_pc8b", PCPlus8D, 32'h0000_0004);

    // Random mix of fetch enable, stall and redirect.
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 9) == 0, $urandom());

    // Asynchronous reset mid-cycle with two entries queued.
    step(0, 0, 1, 32'h0000_0040);
    repeat (2) step(1, 1, 0, 32'h0);
    chk("t6_count2", {29'b0, Count}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", {31'b0, ValidD}, 32'd0);
    chk("t6_count", {29'b0, Count}, 32'd0);
    chk("t6_pcf", PCF, RESET_PC);
    chk("t6_instr", InstrD, 32'h0);
    chk("t6_pc8", PCPlus8D, RESET_PC + 32'd8);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) step(1, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
